// File: rtl/shift_engine.sv
// Framed serial/parallel shift engine: loads a word, shifts it out on shift strobes
// while shifting a received word in, with per-frame bit order and load/busy/done handshake.
module shift_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sampleEdge,
    input  logic             shiftEdge,
    input  logic             load,
    input  logic             lsbFirst,
    input  logic             abort,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   shift_mem_q, shift_mem_d;
    logic [WIDTH-1:0]   rx_word_q,   rx_word_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic               sample_q,    sample_d;
    logic               order_q,     order_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [WIDTH-1:0]   shifted;

    // Shift uses the previously captured sample, so a same-cycle sample lands on the next shift
    always_comb begin
        if (order_q) begin
            shifted = {sample_q, shift_mem_q[WIDTH-1:1]};
        end else begin
            shifted = {shift_mem_q[WIDTH-2:0], sample_q};
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        shift_mem_d = shift_mem_q;
        rx_word_d   = rx_word_q;
        bit_cnt_d   = bit_cnt_q;
        sample_d    = sample_q;
        order_d     = order_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_mem_d = parallelDataIn;
                    order_d     = lsbFirst;
                    bit_cnt_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (abort) begin
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    if (sampleEdge) begin
                        sample_d = serialDataIn;
                    end
                    if (shiftEdge) begin
                        shift_mem_d = shifted;
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                        // Last bit: publish the word now so it is valid alongside done
                        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                            rx_word_d = shifted;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_mem_q <= '0;
            rx_word_q   <= '0;
            bit_cnt_q   <= '0;
            sample_q    <= 1'b0;
            order_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_mem_q <= shift_mem_d;
            rx_word_q   <= rx_word_d;
            bit_cnt_q   <= bit_cnt_d;
            sample_q    <= sample_d;
            order_q     <= order_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign serialDataOut   = order_q ? shift_mem_q[0] : shift_mem_q[WIDTH-1];
    assign parallelDataOut = rx_word_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
